// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_pkg                                                    |
// | Description : Shared defaults and divisor helpers for the UART timing     |
// |               generators. The BAUD_DIV_* functions turn a source clock,   |
// |               baud rate and oversampling ratio into an integer divisor    |
// |               plus a FRAC_W-bit fraction for baud_tick_gen.              |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_CNT_W  = 16;
    localparam int UART_FRAC_W = 4;
    localparam int UART_OVS    = 16;

    // Ceiling log2; used to size the oversampling counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Divisor in units of 2^-frac_w, rounded to nearest. Integer and fraction
    // are both cut from this single value so they always form a consistent
    // pair (no separate rounding of the fraction overflowing into the int).
    function automatic longint unsigned baud_div_scaled(
        input longint unsigned src_hz,
        input longint unsigned baud_hz,
        input longint unsigned ovs,
        input int              frac_w
    );
        longint unsigned den;
        den = baud_hz * ovs;
        return ((src_hz << frac_w) + (den >> 1)) / den;
    endfunction

    function automatic int BAUD_DIV_INT(
        input longint unsigned src_hz,
        input longint unsigned baud_hz,
        input longint unsigned ovs,
        input int              frac_w = UART_FRAC_W
    );
        return int'(baud_div_scaled(src_hz, baud_hz, ovs, frac_w) >> frac_w);
    endfunction

    function automatic int BAUD_DIV_FRAC(
        input longint unsigned src_hz,
        input longint unsigned baud_hz,
        input longint unsigned ovs,
        input int              frac_w = UART_FRAC_W
    );
        return int'(baud_div_scaled(src_hz, baud_hz, ovs, frac_w)
                    & ((64'd1 << frac_w) - 64'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/frac_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frac_accum                                                  |
// | Description : FRAC_W-bit fractional phase accumulator with carry-out.     |
// |               Each step adds i_frac to the accumulator; the carry of that |
// |               add is held until the next step so the owner can stretch    |
// |               the period that just started by one cycle.                  |
// | Ports       : clk      - clock, rising edge                               |
// |               rst      - synchronous active-high reset                    |
// |               i_clr    - clear accumulator and carry (phase re-align)     |
// |               i_step   - accumulate i_frac this edge                      |
// |               i_frac   - fractional increment                             |
// |               o_carry  - carry out of the most recent step                |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module frac_accum #(
    parameter int FRAC_W = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_step,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_carry
);

    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (i_step) begin
            {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, i_frac};
        end
    end

    assign o_carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : baud_tick_gen                                               |
// | Description : UART timing strobe generator. Produces an oversampling tick |
// |               with a fractional average divisor, plus bit-boundary and    |
// |               mid-bit strobes derived from the oversampling count.        |
// |               The divisor is reloadable through a load/ack handshake and  |
// |               the phase can be re-aligned with i_restart.                 |
// | Ports       : src_clk     - clock, rising edge                            |
// |               rst         - synchronous active-high reset                 |
// |               i_en        - count enable (low: all counters hold)         |
// |               i_restart   - phase re-align pulse                          |
// |               i_div_int   - requested integer divisor (>= 2)              |
// |               i_div_frac  - requested fraction, units of 2^-FRAC_W        |
// |               i_div_load  - load request for i_div_int/i_div_frac         |
// |               o_div_ack   - pulse: new divisor took effect                |
// |               o_div_err   - pulse: load rejected (i_div_int < 2)          |
// |               o_os_tick   - oversampling strobe                           |
// |               o_mid_tick  - mid-bit sample strobe                         |
// |               o_bit_tick  - bit-boundary strobe                           |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CNT_W            = UART_CNT_W,
    parameter int FRAC_W           = UART_FRAC_W,
    parameter int OVS              = UART_OVS,    // power of two, >= 1
    parameter int DEFAULT_DIV_INT  = 27,
    parameter int DEFAULT_DIV_FRAC = 2
)(
    input  logic              src_clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_restart,
    input  logic [CNT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    output logic              o_div_ack,
    output logic              o_div_err,
    output logic              o_os_tick,
    output logic              o_mid_tick,
    output logic              o_bit_tick
);

    localparam int c_os_w = (OVS > 1) ? clog2(OVS) : 1;
    localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVS - 1);
    // With OVS=1 both compare values are 0, so every os_tick is also a
    // bit and mid tick.
    localparam logic [c_os_w-1:0] c_os_mid  = (OVS > 1) ? c_os_w'(OVS / 2 - 1) : '0;

    logic [CNT_W-1:0]  r_cnt;
    logic [c_os_w-1:0] r_os_cnt;
    logic [CNT_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic              r_pend_vld;
    logic [CNT_W-1:0]  r_pend_int;
    logic [FRAC_W-1:0] r_pend_frac;
    logic              r_os_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;
    logic              r_div_ack;
    logic              r_div_err;

    logic              w_carry;
    logic              w_load_ok;
    logic              w_load_bad;
    logic              w_pend_vld;
    logic [CNT_W-1:0]  w_pend_int;
    logic [FRAC_W-1:0] w_pend_frac;
    logic [CNT_W:0]    w_term;
    logic              w_wrap;
    logic              w_apply;
    logic [CNT_W-1:0]  w_div_int_nxt;
    logic [FRAC_W-1:0] w_div_frac_nxt;

    assign w_load_ok  = i_div_load && (i_div_int >= CNT_W'(2));
    assign w_load_bad = i_div_load && !w_load_ok;

    // A load arriving on the same edge as an application point is treated as
    // the newest pending value, so it takes effect immediately.
    assign w_pend_vld  = w_load_ok || r_pend_vld;
    assign w_pend_int  = w_load_ok ? i_div_int  : r_pend_int;
    assign w_pend_frac = w_load_ok ? i_div_frac : r_pend_frac;

    // Last count of the current period: div_int - 1 + carry, one bit wider
    // so the carry cannot overflow. The >= (rather than ==) lets a period
    // whose divisor shrank while disabled end on the next enabled edge
    // instead of running the counter all the way round.
    assign w_term = {1'b0, r_div_int} - (CNT_W + 1)'(1) + (CNT_W + 1)'(w_carry);
    assign w_wrap = i_en && !i_restart && ({1'b0, r_cnt} >= w_term);

    assign w_apply = w_pend_vld && (i_restart || w_wrap || !i_en);

    assign w_div_int_nxt  = w_apply ? w_pend_int  : r_div_int;
    assign w_div_frac_nxt = w_apply ? w_pend_frac : r_div_frac;

    // The accumulate at a wrap uses the divisor of the period starting there,
    // so a freshly applied fraction governs that period's carry.
    frac_accum #(
        .FRAC_W (FRAC_W)
    ) u_frac_accum (
        .clk     (src_clk),
        .rst     (rst),
        .i_clr   (i_restart),
        .i_step  (w_wrap),
        .i_frac  (w_div_frac_nxt),
        .o_carry (w_carry)
    );

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_os_cnt    <= '0;
            r_div_int   <= CNT_W'(DEFAULT_DIV_INT);
            r_div_frac  <= FRAC_W'(DEFAULT_DIV_FRAC);
            r_pend_vld  <= 1'b0;
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_os_tick   <= 1'b0;
            r_mid_tick  <= 1'b0;
            r_bit_tick  <= 1'b0;
            r_div_ack   <= 1'b0;
            r_div_err   <= 1'b0;
        end else begin
            r_os_tick  <= w_wrap;
            r_bit_tick <= w_wrap && (r_os_cnt == c_os_last);
            r_mid_tick <= w_wrap && (r_os_cnt == c_os_mid);
            r_div_ack  <= w_apply;
            r_div_err  <= w_load_bad;

            if (i_restart) begin
                r_cnt    <= '0;
                r_os_cnt <= '0;
            end else if (w_wrap) begin
                r_cnt    <= '0;
                r_os_cnt <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + c_os_w'(1);
            end else if (i_en) begin
                r_cnt    <= r_cnt + CNT_W'(1);
            end

            r_div_int  <= w_div_int_nxt;
            r_div_frac <= w_div_frac_nxt;

            if (w_apply) begin
                r_pend_vld <= 1'b0;
            end else if (w_load_ok) begin
                r_pend_vld  <= 1'b1;
                r_pend_int  <= i_div_int;
                r_pend_frac <= i_div_frac;
            end
        end
    end

    assign o_os_tick  = r_os_tick;
    assign o_mid_tick = r_mid_tick;
    assign o_bit_tick = r_bit_tick;
    assign o_div_ack  = r_div_ack;
    assign o_div_err  = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_baud_tick_gen                                            |
// | Description : Self-checking bench for baud_tick_gen (OVS=4, FRAC_W=4).    |
// |               Directed scenario tasks plus a randomized run checked       |
// |               cycle by cycle against a period/fraction reference model.   |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_baud_tick_gen;

    localparam int CNT_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int OVS      = 4;
    localparam int DEF_INT  = 27;
    localparam int DEF_FRAC = 2;
    localparam int FRAC_ONE = 1 << FRAC_W;

    logic              src_clk  = 1'b0;
    logic              rst      = 1'b1;
    logic              en       = 1'b0;
    logic              restart  = 1'b0;
    logic              div_load = 1'b0;
    logic [CNT_W-1:0]  div_int  = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_ack;
    logic              div_err;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;

    int n_cmp = 0;
    int n_bad = 0;

    baud_tick_gen #(
        .CNT_W            (CNT_W),
        .FRAC_W           (FRAC_W),
        .OVS              (OVS),
        .DEFAULT_DIV_INT  (DEF_INT),
        .DEFAULT_DIV_FRAC (DEF_FRAC)
    ) dut (
        .src_clk    (src_clk),
        .rst        (rst),
        .i_en       (en),
        .i_restart  (restart),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .i_div_load (div_load),
        .o_div_ack  (div_ack),
        .o_div_err  (div_err),
        .o_os_tick  (os_tick),
        .o_mid_tick (mid_tick),
        .o_bit_tick (bit_tick)
    );

    always #5 src_clk = ~src_clk;

    // ------------------------------------------------------------------
    // Reference model: tracks elapsed enabled edges of the current period,
    // its extra carry cycle, the fractional remainder and the tick index.
    // Inputs change on negedges, so they are stable at the posedge here.
    // ------------------------------------------------------------------
    int m_el, m_cy, m_acc, m_os, m_div, m_frac, m_pint, m_pfrac;
    bit m_pv;
    bit e_os, e_mid, e_bit, e_ack, e_err;
    bit mo_ok, mo_peff, mo_wrap, mo_apply;
    int mo_pint, mo_pfrac, mo_sum;

    always @(posedge src_clk) begin
        if (rst) begin
            m_el = 0; m_cy = 0; m_acc = 0; m_os = 0;
            m_div = DEF_INT; m_frac = DEF_FRAC; m_pv = 0; m_pint = 0; m_pfrac = 0;
            e_os = 0; e_mid = 0; e_bit = 0; e_ack = 0; e_err = 0;
        end else begin
            mo_ok    = div_load && (int'(div_int) >= 2);
            e_err    = div_load && !mo_ok;
            mo_peff  = mo_ok || m_pv;
            mo_pint  = mo_ok ? int'(div_int)  : m_pint;
            mo_pfrac = mo_ok ? int'(div_frac) : m_pfrac;
            mo_wrap  = en && !restart && (m_el + 1 >= m_div + m_cy);
            mo_apply = mo_peff && (restart || mo_wrap || !en);
            e_os  = mo_wrap;
            e_bit = mo_wrap && (m_os == OVS - 1);
            e_mid = mo_wrap && (m_os == OVS / 2 - 1);
            e_ack = mo_apply;
            if (mo_apply) begin
                m_div = mo_pint; m_frac = mo_pfrac; m_pv = 0;
            end else if (mo_ok) begin
                m_pv = 1; m_pint = mo_pint; m_pfrac = mo_pfrac;
            end
            if (restart) begin
                m_el = 0; m_cy = 0; m_acc = 0; m_os = 0;
            end else if (mo_wrap) begin
                mo_sum = m_acc + m_frac;
                m_cy   = (mo_sum >= FRAC_ONE) ? 1 : 0;
                m_acc  = mo_sum % FRAC_ONE;
                m_el   = 0;
                m_os   = (m_os + 1) % OVS;
            end else if (en) begin
                m_el = m_el + 1;
            end
        end
    end

    // Waits for the next os_tick sample; n = negedges waited, acks = div_ack
    // samples seen on the way (including the tick sample itself).
    task automatic wait_tick(output int n, output int acks, input int limit);
        n = 0;
        acks = 0;
        do begin
            @(negedge src_clk);
            n++;
            if (div_ack) acks++;
        end while (!os_tick && n < limit);
        if (!os_tick) begin
            n_cmp++; n_bad++;
            $display("FAIL tick_timeout: got no os_tick, required one within %0d cycles", limit);
        end
    endtask

    // Restart with a simultaneous load; returns on the negedge after the
    // restart edge with restart/load released.
    task automatic restart_with(input int di, input int df);
        @(negedge src_clk);
        en = 1'b1; restart = 1'b1; div_load = 1'b1;
        div_int = CNT_W'(di); div_frac = FRAC_W'(df);
        @(negedge src_clk);
        restart = 1'b0; div_load = 1'b0;
    endtask

    task automatic test_reset;
        int n, a;
        @(negedge src_clk);
        rst = 1'b1; en = 1'b1; restart = 1'b0; div_load = 1'b0;
        @(negedge src_clk);
        n_cmp++;
        if ({os_tick, mid_tick, bit_tick, div_ack, div_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {os_tick, mid_tick, bit_tick, div_ack, div_err});
        end
        rst = 1'b0;
        wait_tick(n, a, 100);
        n_cmp++;
        if (n !== DEF_INT) begin
            n_bad++; $display("FAIL first_latency: got %0d required %0d", n, DEF_INT);
        end
        n_cmp++;
        if (a !== 0) begin
            n_bad++; $display("FAIL reset_no_ack: got %0d acks required 0", a);
        end
    endtask

    task automatic test_integer;
        int n, a;
        bit want_mid, want_bit;
        restart_with(4, 0);
        n_cmp++;
        if (div_ack !== 1'b1) begin
            n_bad++; $display("FAIL int_restart_ack: got %b required 1", div_ack);
        end
        for (int k = 1; k <= 12; k++) begin
            wait_tick(n, a, 50);
            want_mid = (k % 4 == 2);
            want_bit = (k % 4 == 0);
            n_cmp++;
            if (n !== 4) begin
                n_bad++; $display("FAIL int_period[%0d]: got %0d required 4", k, n);
            end
            n_cmp++;
            if (mid_tick !== want_mid) begin
                n_bad++; $display("FAIL int_mid[%0d]: got %b required %b", k, mid_tick, want_mid);
            end
            n_cmp++;
            if (bit_tick !== want_bit) begin
                n_bad++; $display("FAIL int_bit[%0d]: got %b required %b", k, bit_tick, want_bit);
            end
        end
    endtask

    task automatic test_fractional;
        int n, a, total;
        int exp_p[7] = '{3, 3, 4, 3, 4, 3, 4};
        restart_with(3, 8);
        for (int k = 0; k < 7; k++) begin
            wait_tick(n, a, 50);
            n_cmp++;
            if (n !== exp_p[k]) begin
                n_bad++; $display("FAIL frac_period[%0d]: got %0d required %0d", k, n, exp_p[k]);
            end
        end
        total = 0;
        for (int k = 0; k < 1000; k++) begin
            wait_tick(n, a, 50);
            total += n;
        end
        n_cmp++;
        if (total < 3499 || total > 3501) begin
            n_bad++; $display("FAIL frac_total_1000: got %0d required 3500+-1", total);
        end
    endtask

    task automatic test_load_timing;
        int n, a;
        restart_with(6, 0);
        wait_tick(n, a, 50);
        @(negedge src_clk);
        div_load = 1'b1; div_int = CNT_W'(10); div_frac = '0;
        @(negedge src_clk);
        div_load = 1'b0;
        n_cmp++;
        if (div_ack !== 1'b0) begin
            n_bad++; $display("FAIL load_early_ack: got %b required 0", div_ack);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 4) begin
            n_bad++; $display("FAIL load_old_period: got %0d required 4", n);
        end
        n_cmp++;
        if (a !== 1 || div_ack !== 1'b1) begin
            n_bad++; $display("FAIL load_ack_at_wrap: got %0d acks (ack at wrap %b) required 1 (1)", a, div_ack);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 10 || a !== 0) begin
            n_bad++; $display("FAIL load_new_period: got %0d/%0d acks required 10/0", n, a);
        end
        @(negedge src_clk);
        div_load = 1'b1; div_int = CNT_W'(7);
        @(negedge src_clk);
        div_int = CNT_W'(5);
        @(negedge src_clk);
        div_load = 1'b0;
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 7 || a !== 1) begin
            n_bad++; $display("FAIL double_load_wrap: got %0d/%0d acks required 7/1", n, a);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 5 || a !== 0) begin
            n_bad++; $display("FAIL double_load_last_wins: got %0d/%0d acks required 5/0", n, a);
        end
    endtask

    task automatic test_reject;
        int n, a;
        @(negedge src_clk);
        div_load = 1'b1; div_int = CNT_W'(1);
        @(negedge src_clk);
        div_load = 1'b0;
        n_cmp++;
        if (div_err !== 1'b1 || div_ack !== 1'b0) begin
            n_bad++; $display("FAIL reject_err: got err=%b ack=%b required err=1 ack=0", div_err, div_ack);
        end
        @(negedge src_clk);
        n_cmp++;
        if (div_err !== 1'b0) begin
            n_bad++; $display("FAIL reject_err_pulse: got %b required 0", div_err);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 2 || a !== 0) begin
            n_bad++; $display("FAIL reject_period: got %0d/%0d acks required 2/0", n, a);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 5 || a !== 0) begin
            n_bad++; $display("FAIL reject_unchanged: got %0d/%0d acks required 5/0", n, a);
        end
    endtask

    task automatic test_restart_wrap;
        int n, a;
        repeat (4) @(negedge src_clk);
        restart = 1'b1;
        @(negedge src_clk);
        restart = 1'b0;
        n_cmp++;
        if (os_tick !== 1'b0 || div_ack !== 1'b0) begin
            n_bad++; $display("FAIL restart_no_tick: got tick=%b ack=%b required 0 0", os_tick, div_ack);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 5 || mid_tick !== 1'b0 || bit_tick !== 1'b0) begin
            n_bad++; $display("FAIL restart_realign: got %0d mid=%b bit=%b required 5 0 0", n, mid_tick, bit_tick);
        end
        wait_tick(n, a, 50);
        n_cmp++;
        if (n !== 5 || mid_tick !== 1'b1) begin
            n_bad++; $display("FAIL restart_os_cnt: got %0d mid=%b required 5 1", n, mid_tick);
        end
    endtask

    task automatic test_en_stretch;
        int n, a;
        @(negedge src_clk);
        @(negedge src_clk);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge src_clk);
            n_cmp++;
            if (os_tick !== 1'b0) begin
                n_bad++; $display("FAIL en_low_tick[%0d]: got %b required 0", k, os_tick);
            end
        end
        en = 1'b1;
        wait_tick(n, a, 50);
        n_cmp++;
        if (n + 9 !== 12) begin
            n_bad++; $display("FAIL en_stretch: got period %0d required 12", n + 9);
        end
    endtask

    task automatic test_reset_pending;
        int n, a;
        @(negedge src_clk);
        div_load = 1'b1; div_int = CNT_W'(9); div_frac = '0;
        @(negedge src_clk);
        div_load = 1'b0; rst = 1'b1;
        n_cmp++;
        if (div_ack !== 1'b0) begin
            n_bad++; $display("FAIL pend_not_applied: got %b required 0", div_ack);
        end
        @(negedge src_clk);
        n_cmp++;
        if ({os_tick, mid_tick, bit_tick, div_ack, div_err} !== 5'b0) begin
            n_bad++; $display("FAIL midrun_reset_outputs: got %b required 00000",
                              {os_tick, mid_tick, bit_tick, div_ack, div_err});
        end
        rst = 1'b0; en = 1'b1;
        wait_tick(n, a, 100);
        n_cmp++;
        if (n !== DEF_INT || a !== 0) begin
            n_bad++; $display("FAIL midrun_reset_default1: got %0d/%0d acks required %0d/0", n, a, DEF_INT);
        end
        wait_tick(n, a, 100);
        n_cmp++;
        if (n !== DEF_INT || a !== 0) begin
            n_bad++; $display("FAIL midrun_reset_default2: got %0d/%0d acks required %0d/0", n, a, DEF_INT);
        end
    endtask

    task automatic test_random;
        logic [4:0] got, want;
        @(negedge src_clk);
        rst = 1'b1; en = 1'b0; restart = 1'b0; div_load = 1'b0;
        @(negedge src_clk);
        rst = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge src_clk);
            got  = {os_tick, mid_tick, bit_tick, div_ack, div_err};
            want = {e_os, e_mid, e_bit, e_ack, e_err};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random[%0d] {os,mid,bit,ack,err}: got %b required %b", k, got, want);
            end
            en       = ($urandom % 8) != 0;
            restart  = ($urandom % 40) == 0;
            div_load = ($urandom % 25) == 0;
            div_int  = CNT_W'($urandom_range(0, 12));
            div_frac = FRAC_W'($urandom);
        end
        en = 1'b0; restart = 1'b0; div_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_integer();
        test_fractional();
        test_load_timing();
        test_reject();
        test_restart_wrap();
        test_en_stretch();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
